cnn_stream_bridge: RTL and testbench

Parametrised AXI-Stream bridge between the DMA and a sliding-window CNN accelerator. It frames one image per transaction, forwards input pixels to the accelerator, and buffers the accelerator's results in an output FIFO with credit-based input throttling. It drives `m_axis_tlast` from a per-frame result count and flags framing and overflow errors. The block sits between the AXI DMA streams and the CNN accelerator core.

---
 rtl/cnn_stream_bridge.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cnn_stream_bridge.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cnn_stream_bridge
// Purpose  : AXI-Stream bridge between the DMA and a sliding-window CNN
//            accelerator. Frames one DxD image per transaction and forwards
//            its pixels to the accelerator. Results are buffered in a
//            first-word-fall-through FIFO, and input is throttled so that
//            HEADROOM slots stay free for in-flight results. Output tlast
//            is generated from a per-frame result count. Framing and
//            overflow errors are flagged.
// Ports    : clk_i / resetn_i          clock, async active-low reset
//            image_dimension           image side D, sampled at frame start
//            clr_err_i                 clears the sticky error flags
//            s_axis_*                  input pixel stream (from DMA)
//            m_axis_*                  output result stream (to DMA)
//            acc_pixel_o/acc_valid_o   pixel to the accelerator
//            acc_stall_o               accelerator must hold its pipeline
//            acc_result_i/_valid_i     result from the accelerator
//            frame_done_o, cfg_err_o   one-cycle status pulses
//            tlast_err_o, ovf_err_o    sticky error flags
//            state_o                   FSM state for debug
// Revision : 1.0 - initial release
// ============================================================================
module cnn_stream_bridge #(
   parameter int DATA_RES     = 8,
   parameter int KERNEL_WIDTH = 3,
   parameter int MAX_DIM      = 32,
   parameter int FIFO_DEPTH   = 16,
   parameter int HEADROOM     = 4
) (
   input  logic                         clk_i,
   input  logic                         resetn_i,
   input  logic [$clog2(MAX_DIM+1)-1:0] image_dimension,
   input  logic                         clr_err_i,
   input  logic [DATA_RES-1:0]          s_axis_tdata,
   input  logic                         s_axis_tvalid,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   output logic [DATA_RES-1:0]          m_axis_tdata,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready,
   output logic [DATA_RES-1:0]          acc_pixel_o,
   output logic                         acc_valid_o,
   output logic                         acc_stall_o,
   input  logic [DATA_RES-1:0]          acc_result_i,
   input  logic                         acc_result_valid_i,
   output logic                         frame_done_o,
   output logic                         cfg_err_o,
   output logic                         tlast_err_o,
   output logic                         ovf_err_o,
   output logic [1:0]                   state_o
);

   localparam int DIM_W = $clog2(MAX_DIM + 1);
   localparam int CNT_W = $clog2(MAX_DIM * MAX_DIM + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [CNT_W-1:0]    in_cnt;
   logic [CNT_W-1:0]    out_cnt;
   logic [CNT_W-1:0]    in_total;
   logic [CNT_W-1:0]    out_total;
   logic [CNT_W-1:0]    dim_ext;
   logic [CNT_W-1:0]    out_side;

   logic [DATA_RES:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [OCC_W-1:0]    occ;
   logic [OCC_W-1:0]    free;
   logic [DATA_RES:0]   head;

   logic                empty;
   logic                full;
   logic                accept;
   logic                pop;
   logic                push;
   logic                drop;
   logic                res_room;
   logic                out_open;
   logic                last_in;
   logic                last_out;
   logic                tlast_pop;
   logic                cfg_ok;
   logic                frame_start;
   logic                cfg_bad;

   // ------------------------------------------------------------------------
   // Frame geometry: widen D before multiplying so D*D never truncates.
   // ------------------------------------------------------------------------
   assign dim_ext  = CNT_W'(image_dimension);
   assign out_side = dim_ext - CNT_W'(KERNEL_WIDTH) + CNT_W'(1);
   assign cfg_ok   = (image_dimension >= DIM_W'(KERNEL_WIDTH));

   assign frame_start = (state == IDLE) && s_axis_tvalid && cfg_ok;
   assign cfg_bad     = (state == IDLE) && s_axis_tvalid && !cfg_ok;

   // ------------------------------------------------------------------------
   // FIFO status and handshakes
   // ------------------------------------------------------------------------
   assign empty    = (occ == '0);
   assign full     = (occ == OCC_W'(FIFO_DEPTH));
   assign free     = OCC_W'(FIFO_DEPTH) - occ;
   assign head     = mem[rd_ptr];

   assign pop      = !empty && m_axis_tready;
   // A full FIFO still takes a result when the head leaves in the same cycle.
   assign res_room = !full || pop;
   assign out_open = (out_cnt != out_total);
   assign push     = acc_result_valid_i && res_room && out_open;
   assign drop     = acc_result_valid_i && !(res_room && out_open);
   assign last_out = ((out_cnt + CNT_W'(1)) == out_total);

   assign accept    = s_axis_tvalid && s_axis_tready;
   assign last_in   = ((in_cnt + CNT_W'(1)) == in_total);
   assign tlast_pop = pop && head[DATA_RES];

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and input-side ready. Ready depends only on registered
   // state, never on s_axis_tvalid.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            s_axis_tready = (in_cnt < in_total) && (free > OCC_W'(HEADROOM));
            if (tlast_pop) begin
               state_nxt = IDLE;
            end else if (s_axis_tvalid && s_axis_tready && last_in) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (tlast_pop) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Frame counters and latched totals
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         in_cnt    <= '0;
         out_cnt   <= '0;
         in_total  <= '0;
         out_total <= '0;
      end else if (frame_start) begin
         in_total  <= dim_ext * dim_ext;
         out_total <= out_side * out_side;
         in_cnt    <= '0;
         out_cnt   <= '0;
      end else begin
         if (accept) begin
            in_cnt <= in_cnt + CNT_W'(1);
         end
         if (push) begin
            out_cnt <= out_cnt + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output FIFO. Storage needs no reset: the occupancy count gates it.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= {last_out, acc_result_i};
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
   end

   // ------------------------------------------------------------------------
   // Status pulses and sticky errors (a new error beats a same-cycle clear)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         frame_done_o <= 1'b0;
         cfg_err_o    <= 1'b0;
         tlast_err_o  <= 1'b0;
         ovf_err_o    <= 1'b0;
      end else begin
         frame_done_o <= tlast_pop && (state != IDLE);
         cfg_err_o    <= cfg_bad;

         if (accept && (s_axis_tlast != last_in)) begin
            tlast_err_o <= 1'b1;
         end else if (clr_err_i) begin
            tlast_err_o <= 1'b0;
         end

         if (drop) begin
            ovf_err_o <= 1'b1;
         end else if (clr_err_i) begin
            ovf_err_o <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = empty ? '0 : head[DATA_RES-1:0];
   assign m_axis_tlast  = !empty && head[DATA_RES];

   assign acc_pixel_o   = s_axis_tdata;
   assign acc_valid_o   = accept;
   assign acc_stall_o   = (free <= OCC_W'(HEADROOM)) || !m_axis_tready;

   assign state_o       = state;

endmodule
`default_nettype wire

// File: tb/tb_cnn_stream_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cnn_stream_bridge
// Purpose  : Scoreboard bench for cnn_stream_bridge. A behavioural
//            accelerator sums each KxK window of the forwarded pixels. The
//            expected output beats are derived from the frame contents
//            when each frame is issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_stream_bridge;

   localparam int DATA_RES   = 8;
   localparam int K          = 3;
   localparam int MAX_DIM    = 32;
   localparam int FIFO_DEPTH = 16;
   localparam int HEADROOM   = 4;
   localparam int DIM_W      = $clog2(MAX_DIM + 1);

   logic                clk_i = 1'b0;
   logic                resetn_i;
   logic [DIM_W-1:0]    image_dimension;
   logic                clr_err_i;
   logic [DATA_RES-1:0] s_axis_tdata;
   logic                s_axis_tvalid;
   logic                s_axis_tlast;
   logic                s_axis_tready;
   logic [DATA_RES-1:0] m_axis_tdata;
   logic                m_axis_tvalid;
   logic                m_axis_tlast;
   logic                m_axis_tready;
   logic [DATA_RES-1:0] acc_pixel_o;
   logic                acc_valid_o;
   logic                acc_stall_o;
   logic [DATA_RES-1:0] acc_result_i;
   logic                acc_result_valid_i;
   logic                frame_done_o;
   logic                cfg_err_o;
   logic                tlast_err_o;
   logic                ovf_err_o;
   logic [1:0]          state_o;

   cnn_stream_bridge #(
      .DATA_RES(DATA_RES), .KERNEL_WIDTH(K), .MAX_DIM(MAX_DIM),
      .FIFO_DEPTH(FIFO_DEPTH), .HEADROOM(HEADROOM)
   ) dut (
      .clk_i(clk_i), .resetn_i(resetn_i), .image_dimension(image_dimension),
      .clr_err_i(clr_err_i),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .acc_pixel_o(acc_pixel_o), .acc_valid_o(acc_valid_o),
      .acc_stall_o(acc_stall_o), .acc_result_i(acc_result_i),
      .acc_result_valid_i(acc_result_valid_i), .frame_done_o(frame_done_o),
      .cfg_err_o(cfg_err_o), .tlast_err_o(tlast_err_o),
      .ovf_err_o(ovf_err_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0]  exp_q [$];     // {tlast, tdata} expected on m_axis
   logic [7:0]  pend  [$];     // results waiting inside the accelerator model
   logic [7:0]  inj   [$];     // results forced regardless of stall
   logic [7:0]  frame_pix [0:1023];
   logic [7:0]  acc_pix   [0:1023];
   int          acc_dim    = 1;
   int          acc_idx    = 0;
   int          res_cnt    = 0;
   int          done_cnt   = 0;
   int          beats      = 0;
   bit          force_mode = 1'b0;
   bit          pend_done  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: one result per KxK window, raster order, tlast on the last.
   task automatic push_expected(input int d);
      int s;
      for (int r = K - 1; r < d; r++) begin
         for (int c = K - 1; c < d; c++) begin
            s = 0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  s += frame_pix[(r - i) * d + (c - j)];
            exp_q.push_back({(r == d - 1) && (c == d - 1), s[7:0]});
         end
      end
   endtask

   // Accelerator model: sums each window as its last pixel arrives and
   // releases results only while not stalled (unless forcing).
   initial begin
      int r, c, s;
      acc_result_valid_i = 1'b0;
      acc_result_i       = '0;
      forever begin
         @(negedge clk_i);
         if (!resetn_i) begin
            pend.delete();
            inj.delete();
            acc_idx = 0;
            acc_result_valid_i = 1'b0;
            continue;
         end
         if (state_o == 2'b00) acc_idx = 0;
         if (acc_valid_o) begin
            acc_pix[acc_idx] = acc_pixel_o;
            r = acc_idx / acc_dim;
            c = acc_idx % acc_dim;
            if (r >= K - 1 && c >= K - 1) begin
               s = 0;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++)
                     s += acc_pix[(r - i) * acc_dim + (c - j)];
               pend.push_back(s[7:0]);
            end
            acc_idx++;
         end
         if (force_mode) begin
            if (inj.size() > 0) begin
               acc_result_valid_i = 1'b1;
               acc_result_i = inj.pop_front();
            end else begin
               acc_result_valid_i = 1'b0;
            end
         end else if (pend.size() > 0 && !acc_stall_o) begin
            acc_result_valid_i = 1'b1;
            acc_result_i = pend.pop_front();
            res_cnt++;
         end else begin
            acc_result_valid_i = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on every output handshake and checks that
   // frame_done follows the tlast handshake by one cycle.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk_i);
         if (!resetn_i) begin
            exp_q.delete();
            pend_done = 1'b0;
            continue;
         end
         if (frame_done_o || pend_done) begin
            chk("frame_done", frame_done_o, pend_done);
            if (pend_done) chk("state_after_done", state_o, 2'b00);
         end
         if (frame_done_o) done_cnt++;
         pend_done = 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("tdata", m_axis_tdata, e[7:0]);
               chk("tlast", m_axis_tlast, e[8]);
               pend_done = m_axis_tlast;
            end
         end
      end
   end

   task automatic fill_pixels(input int d);
      for (int i = 0; i < d * d; i++) frame_pix[i] = 8'($urandom);
   endtask

   // Called just after a rising edge; leaves just after a rising edge.
   task automatic send_pixels(input int n, input int tlast_at);
      bit ok;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk_i); #1;
         end
         s_axis_tdata  = frame_pix[i];
         s_axis_tlast  = (i + 1 == tlast_at);
         s_axis_tvalid = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk_i);
            if (s_axis_tready) ok = 1'b1;
            @(posedge clk_i); #1;
         end
         if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL input_handshake_timeout actual=beat%0d required=accepted", i);
            s_axis_tvalid = 1'b0;
            return;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_done(input int base);
      for (int t = 0; t < 5000 && done_cnt == base; t++) @(negedge clk_i);
      chk("frame_done_seen", done_cnt, base + 1);
   endtask

   task automatic run_frame(input int d, input int tlast_at);
      int base, b0;
      @(posedge clk_i); #1;
      acc_dim = d;
      image_dimension = DIM_W'(d);
      fill_pixels(d);
      push_expected(d);
      base = done_cnt;
      b0   = beats;
      send_pixels(d * d, tlast_at);
      wait_done(base);
      chk("beat_count", beats - b0, (d - K + 1) * (d - K + 1));
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic check_reset_values();
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_acc_valid", acc_valid_o, 0);
      chk("rst_frame_done", frame_done_o, 0);
      chk("rst_cfg_err", cfg_err_o, 0);
      chk("rst_tlast_err", tlast_err_o, 0);
      chk("rst_ovf_err", ovf_err_o, 0);
      chk("rst_state", state_o, 0);
      chk("rst_acc_stall", acc_stall_o, 1);
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      resetn_i      = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      force_mode    = 1'b0;
      @(negedge clk_i);
      check_reset_values();
      @(posedge clk_i); #1;
      resetn_i      = 1'b1;
      m_axis_tready = 1'b1;
   endtask

   initial begin
      int base;
      bit seen;
      logic [7:0] v;
      resetn_i        = 1'b0;
      image_dimension = '0;
      clr_err_i       = 1'b0;
      s_axis_tdata    = '0;
      s_axis_tvalid   = 1'b0;
      s_axis_tlast    = 1'b0;
      m_axis_tready   = 1'b0;
      repeat (3) @(negedge clk_i);
      check_reset_values();
      @(posedge clk_i); #1;
      resetn_i      = 1'b1;
      m_axis_tready = 1'b1;

      // Nominal 5x5 frame.
      run_frame(5, 25);
      chk("nom_tlast_err", tlast_err_o, 0);
      chk("nom_ovf_err", ovf_err_o, 0);

      // Backpressure: output held off for 40 cycles after the 2nd result.
      base = res_cnt;
      fork
         run_frame(5, 25);
         begin
            seen = 1'b0;
            for (int t = 0; t < 3000 && !seen; t++) begin
               @(negedge clk_i);
               if (res_cnt >= base + 2) seen = 1'b1;
            end
            chk("bp_second_result", seen, 1);
            @(posedge clk_i); #1;
            m_axis_tready = 1'b0;
            repeat (39) @(posedge clk_i);
            @(negedge clk_i);
            chk("bp_stall_held", acc_stall_o, 1);
            chk("bp_tvalid_held", m_axis_tvalid, 1);
            @(posedge clk_i); #1;
            m_axis_tready = 1'b1;
         end
      join
      chk("bp_ovf_err", ovf_err_o, 0);

      // Bad configuration D=2.
      @(posedge clk_i); #1;
      image_dimension = DIM_W'(2);
      s_axis_tvalid   = 1'b1;
      @(negedge clk_i);
      chk("cfg_tready", s_axis_tready, 0);
      @(posedge clk_i); #1;
      s_axis_tvalid = 1'b0;
      @(negedge clk_i);
      chk("cfg_err_pulse", cfg_err_o, 1);
      chk("cfg_state", state_o, 0);
      chk("cfg_tready_after", s_axis_tready, 0);
      @(negedge clk_i);
      chk("cfg_err_cleared", cfg_err_o, 0);

      // Input tlast on beat 10 of a 4x4 frame.
      run_frame(4, 10);
      chk("tl_err_set", tlast_err_o, 1);
      repeat (5) @(negedge clk_i);
      chk("tl_err_sticky", tlast_err_o, 1);
      @(posedge clk_i); #1;
      clr_err_i = 1'b1;
      @(posedge clk_i); #1;
      clr_err_i = 1'b0;
      @(negedge clk_i);
      chk("tl_err_clear", tlast_err_o, 0);

      // Overflow: 20 forced results into a stalled 16-entry FIFO.
      @(posedge clk_i); #1;
      m_axis_tready   = 1'b0;
      acc_dim         = 7;
      image_dimension = DIM_W'(7);
      fill_pixels(7);
      send_pixels(1, 0);
      base = beats;
      force_mode = 1'b1;
      for (int i = 0; i < 20; i++) begin
         v = 8'($urandom);
         inj.push_back(v);
         if (i < FIFO_DEPTH) exp_q.push_back({1'b0, v});
      end
      @(negedge clk_i);
      @(negedge clk_i);
      chk("ovf_first_latency", m_axis_tvalid, 1);
      repeat (22) @(negedge clk_i);
      chk("ovf_err_set", ovf_err_o, 1);
      chk("ovf_s_tready_low", s_axis_tready, 0);
      chk("ovf_stall", acc_stall_o, 1);
      @(posedge clk_i); #1;
      force_mode    = 1'b0;
      m_axis_tready = 1'b1;
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk_i);
      @(negedge clk_i);
      chk("ovf_retained", beats - base, FIFO_DEPTH);
      chk("ovf_fifo_empty", m_axis_tvalid, 0);

      do_reset();

      // Reset after 12 of 25 inputs, then a 3x3 frame.
      @(posedge clk_i); #1;
      acc_dim         = 5;
      image_dimension = DIM_W'(5);
      fill_pixels(5);
      send_pixels(12, 25);
      chk("mid_state_run", state_o, 2'b01);
      do_reset();
      run_frame(3, 9);
      chk("post_rst_tlast_err", tlast_err_o, 0);
      chk("post_rst_ovf_err", ovf_err_o, 0);

      repeat (5) @(negedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
